// File: rtl/latex_uart_streamer_if.sv
// ---------------------------------------------------------------------------
// latex_uart_streamer_if
// Bundles the control, lookup-fetch and UART signals of latex_uart_streamer.
//   start     : single-cycle request to stream one line
//   line_id   : line to stream, sampled with start
//   line_sel  : latched line_id, driven to the lookup stage
//   char_idx  : character index requested from the lookup stage
//   sel_rhs   : 0 = LHS string, 1 = RHS string
//   char_data : character from the lookup stage, valid 1 cycle after char_idx
//   tx        : UART line, idle high
//   busy      : high while a line is being streamed
//   done      : one-cycle pulse when the final LF stop bit completes
// master = requester / lookup side, slave = streamer.
// ---------------------------------------------------------------------------
interface latex_uart_streamer_if;
    logic       start;
    logic [5:0] line_id;
    logic [5:0] line_sel;
    logic [5:0] char_idx;
    logic       sel_rhs;
    logic [7:0] char_data;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, line_id, char_data,
        input  line_sel, char_idx, sel_rhs, tx, busy, done
    );

    modport slave (
        input  start, line_id, char_data,
        output line_sel, char_idx, sel_rhs, tx, busy, done
    );
endinterface

// File: rtl/latex_uart_streamer.sv
// ---------------------------------------------------------------------------
// latex_uart_streamer
// Walks the packed-ASCII LaTeX strings of one line (LHS, then RHS) from the
// lookup stage and sends "<lhs> = <rhs>\r\n" as 8N1 UART on bus.tx.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : latex_uart_streamer_if.slave (start/line_id in, lookup fetch
//          line_sel/char_idx/sel_rhs out, char_data in, tx/busy/done out)
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   MAX_IDX      : highest character index fetched per side
// Every byte costs ADDR (1) + CAPTURE (1) + FRAME (10*CLKS_PER_BIT) cycles.
// ---------------------------------------------------------------------------
module latex_uart_streamer #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MAX_IDX      = 63
) (
    input logic                  clk,
    input logic                  rst,
    latex_uart_streamer_if.slave bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_FRAME,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_LHS,
        P_SEP,
        P_RHS,
        P_EOL
    } phase_t;

    state_t        r_state;
    phase_t        r_phase;
    logic [5:0]    r_line_sel;
    logic [5:0]    r_char_idx;
    logic          r_sel_rhs;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_const_idx;
    logic [8:0]    r_shift;     // {stop, data[7:0]} still to be sent
    logic [3:0]    r_bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] r_clk_cnt;

    logic [7:0]    w_const_byte;
    logic          w_is_text;
    logic          w_last_const;
    logic          w_at_max;
    logic          w_bit_end;

    always_comb begin
        w_const_byte = 8'h20;
        case (r_phase)
            P_SEP:   w_const_byte = (r_const_idx == 2'd1) ? 8'h3D : 8'h20;
            P_EOL:   w_const_byte = (r_const_idx == 2'd0) ? 8'h0D : 8'h0A;
            default: w_const_byte = 8'h20;
        endcase
    end

    assign w_is_text    = (r_phase == P_LHS) || (r_phase == P_RHS);
    assign w_last_const = (r_phase == P_SEP) ? (r_const_idx == 2'd2)
                                             : (r_const_idx == 2'd1);
    assign w_at_max     = (r_char_idx == 6'(MAX_IDX));
    assign w_bit_end    = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= P_LHS;
            r_line_sel  <= '0;
            r_char_idx  <= '0;
            r_sel_rhs   <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_const_idx <= '0;
            r_shift     <= '1;
            r_bit_cnt   <= '0;
            r_clk_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_line_sel  <= bus.line_id;
                        r_char_idx  <= '0;
                        r_sel_rhs   <= 1'b0;
                        r_phase     <= P_LHS;
                        r_const_idx <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    if (w_is_text && (bus.char_data == 8'h00)) begin
                        // Terminator: no frame, move on to the next phase.
                        r_phase     <= (r_phase == P_LHS) ? P_SEP : P_EOL;
                        r_const_idx <= '0;
                        r_state     <= S_ADDR;
                    end else begin
                        r_tx      <= 1'b0;
                        r_shift   <= {1'b1, (w_is_text ? bus.char_data : w_const_byte)};
                        r_bit_cnt <= '0;
                        r_clk_cnt <= '0;
                        r_state   <= S_FRAME;
                    end
                end

                S_FRAME: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 4'd9) begin
                            r_tx    <= 1'b1;
                            r_state <= S_ADDR;
                            case (r_phase)
                                P_LHS, P_RHS: begin
                                    // A full-length side ends without a terminator fetch.
                                    if (w_at_max) begin
                                        r_phase     <= (r_phase == P_LHS) ? P_SEP : P_EOL;
                                        r_const_idx <= '0;
                                    end else begin
                                        r_char_idx <= r_char_idx + 6'd1;
                                    end
                                end
                                P_SEP: begin
                                    if (w_last_const) begin
                                        r_phase    <= P_RHS;
                                        r_sel_rhs  <= 1'b1;
                                        r_char_idx <= '0;
                                    end else begin
                                        r_const_idx <= r_const_idx + 2'd1;
                                    end
                                end
                                default: begin
                                    if (w_last_const) begin
                                        r_state <= S_DONE;
                                        r_done  <= 1'b1;
                                        r_busy  <= 1'b0;
                                    end else begin
                                        r_const_idx <= r_const_idx + 2'd1;
                                    end
                                end
                            endcase
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[8:1]};
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.line_sel = r_line_sel;
    assign bus.char_idx = r_char_idx;
    assign bus.sel_rhs  = r_sel_rhs;
    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: doc/latex_uart_streamer.md
Name: latex_uart_streamer

Overview:
- Downstream consumer of the transform lookup stage.
- Walks the packed-ASCII LaTeX strings for one selected line, LHS first, then RHS.
- Serializes them as 8N1 UART on a single TX pin in the form "<lhs> = <rhs>\r\n".
- Lets the board stream full transforms instead of showing one byte per side on the parallel outputs.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit; minimum 2.
- MAX_IDX, 63, highest character index fetched per side; index width is 6.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to stream one line
- line_id  input  6  line to stream; sampled with start
- line_sel  output  6  latched line_id, driven to the lookup stage
- char_idx  output  6  character index requested from the lookup stage
- sel_rhs  output  1  0 = fetch from LHS string, 1 = fetch from RHS string
- char_data  input  8  character returned by the lookup stage, valid 1 cycle after char_idx/sel_rhs
- tx  output  1  UART line, idle high
- busy  output  1  high while a line is being streamed
- done  output  1  one-cycle pulse when the final LF stop bit completes

Behaviour:
- Reset (async, any state): tx=1, busy=0, done=0, char_idx=0, sel_rhs=0, line_sel=0, FSM=IDLE, bit counters cleared. A frame in flight is abandoned; tx returns high immediately.
- States: IDLE, ADDR, CAPTURE, FRAME, DONE.
- Phases, in order: LHS, SEP (0x20 0x3D 0x20), RHS, EOL (0x0D 0x0A).
- Start handling:
  - IDLE, start=1: latch line_id into line_sel; char_idx=0, sel_rhs=0, phase=LHS; busy=1 from the next cycle; go to ADDR.
  - start is ignored while busy=1.
- Per-byte cost:
  - ADDR: 1 cycle; char_idx/sel_rhs stable.
  - CAPTURE: 1 cycle; char_data sampled, or a constant selected in SEP/EOL.
  - FRAME: 10*CLKS_PER_BIT cycles, starting the cycle after CAPTURE.
  - Every byte therefore costs 2 + 10*CLKS_PER_BIT cycles, with tx high during the 2 decode cycles.
- FRAME bit order: start bit 0, data LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Transitions out of CAPTURE:
  - LHS/RHS, char_data==0x00: terminator. Send no frame; advance phase; go to ADDR. Costs 2 cycles.
  - LHS/RHS, nonzero: go to FRAME. After FRAME, if char_idx==MAX_IDX the side ends without fetching further (no terminator cycles). Otherwise char_idx+1 and return to ADDR.
  - SEP/EOL: go to FRAME with the constant byte; step through the constants.
- Phase changes:
  - Entering RHS: sel_rhs=1, char_idx=0.
  - After the EOL 0x0A frame: DONE for 1 cycle, with done=1 and busy=0 in that same cycle, then IDLE.
- Empty side: a NUL at index 0 still emits the separator and EOL.
- char_idx and sel_rhs change only on entry to ADDR. line_sel holds for the whole transaction.
- A start pulse in the DONE cycle is ignored; start is accepted from IDLE only.

Test Plan:
- CLKS_PER_BIT=4, line_id=5, lhs="a\0", rhs="b\0", start at cycle 0:
  - tx frames 0x61 0x20 0x3D 0x20 0x62 0x0D 0x0A, each 40 cycles, LSB first.
  - line_sel=5 throughout.
  - done pulses exactly at cycle 299 (298 cycles of work after the start-sample edge); busy falls in the same cycle.
- lhs="\0", rhs="\0":
  - tx carries exactly 0x20 0x3D 0x20 0x0D 0x0A.
  - Total 2+2+5*42 = 214 cycles to done.
- lhs of 64 nonzero bytes 0x41 with no NUL:
  - exactly 64 'A' frames.
  - char_idx never exceeds 63.
  - the separator follows immediately with no terminator cycles.
- rst asserted mid-frame, during data bit 3 of the 0x3D frame:
  - tx=1 and busy=0 immediately.
  - A new start after deassert streams a full line from index 0.
- start pulsed again while busy, and during the DONE cycle:
  - No effect on tx, char_idx or line_sel.
  - Only one done pulse.
- Random strings, random CLKS_PER_BIT in 2..10:
  - A UART monitor decodes exactly lhs+" = "+rhs+"\r\n".
  - Every bit width equals CLKS_PER_BIT.
